regfile_writeback_arbiter: RTL
==============================

Name: regfile_writeback_arbiter

Overview:
- Sits directly upstream of the register file write port and drives its shouldWrite/writeAddress/writeData.
- Merges two write sources:
  - Port A: the in-order pipeline writeback. Highest priority, never back-pressured.
  - Port B: a long-latency unit result (mul/div) with a valid/ready handshake, buffered in a small FIFO.
- Squashes stale port-B results superseded by younger pipeline writes (WAW).
- Exports a pending-destination mask for the hazard unit and a starvation stall request.

Parameters:
- DATA_WIDTH, 32, register data width.
- ADDR_WIDTH, 5, register address width (32 registers).
- FIFO_DEPTH, 2, port-B buffer entries; power of two, 2..8.
- STARVE_LIMIT, 4, consecutive cycles a valid FIFO head may lose to port A before stallRequest asserts; range 1..15.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- wbEnable  in  1  port A write request.
- wbAddress  in  ADDR_WIDTH  port A destination.
- wbData  in  DATA_WIDTH  port A data.
- ldValid  in  1  port B result valid.
- ldReady  out  1  port B ready; equals !fifoFull (combinational from state only).
- ldAddress  in  ADDR_WIDTH  port B destination.
- ldData  in  DATA_WIDTH  port B data.
- shouldWrite  out  1  register file write enable (registered).
- writeAddress  out  ADDR_WIDTH  register file write address (registered).
- writeData  out  DATA_WIDTH  register file write data (registered).
- pendingMask  out  32  bit i = 1 iff a valid FIFO entry targets register i (registered).
- stallRequest  out  1  pipeline must stop issuing writebacks (registered).

Behaviour:
- Reset (async, reset_n low):
  - shouldWrite=0, writeAddress=0, writeData=0, pendingMask=0, stallRequest=0.
  - FIFO emptied, all entries invalid, starvation counter=0, so ldReady=1.
  - Reset mid-operation discards all buffered results. No write is emitted after release until new input arrives.
- Port A:
  - Active when wbEnable=1 and wbAddress!=0. Address 0 is treated as idle.
  - When active, the output register loads {1, wbAddress, wbData} at the posedge. Latency is 1 cycle.
- Port B push:
  - Occurs when ldValid && ldReady at the posedge.
  - ldAddress==0: handshake completes, entry discarded.
  - Same-cycle active port A with wbAddress==ldAddress: entry discarded (B is always older).
  - Otherwise the entry is appended valid.
- Squash: an active port A write to address X clears the valid bit of every FIFO entry with address X in the same edge.
- Pop:
  - Happens when port A is idle and the FIFO is non-empty.
  - Valid head: output register loads {1, addr, data}.
  - Invalid head: entry removed and shouldWrite loads 0.
  - One entry popped per cycle at most.
  - Earliest shouldWrite for a B result is 2 cycles after its handshake cycle.
- Idle: no A and FIFO empty, so shouldWrite loads 0. writeAddress/writeData hold their last values.
- Full/empty:
  - Push and pop in the same cycle are allowed when not full.
  - When full, ldReady=0 even if a pop occurs that cycle (no bypass).
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - Full/empty are distinguished with an extra pointer bit.
- pendingMask: recomputed from post-edge FIFO contents (valid entries only). Bit 0 is always 0.
- Starvation:
  - Counter increments each cycle the head is valid and port A is active.
  - Counter clears on any pop, or when the head becomes invalid/empty.
  - stallRequest loads 1 when the counter reaches STARVE_LIMIT and holds until the head pops.
  - Port A still wins while stallRequest=1. The pipeline must honour the stall within one cycle.
- No combinational path from any input to shouldWrite/writeAddress/writeData/pendingMask/stallRequest.

Test Plan:
- Reset, then A-only: wbEnable=1, wbAddress=5, wbData=0x1234 for one cycle -> next cycle shouldWrite=1, writeAddress=5, writeData=0x1234; following idle cycle shouldWrite=0.
- B-only: push addr 7, data 0xDEAD with A idle -> pendingMask[7]=1 the cycle after the handshake; shouldWrite=1, addr 7, data 0xDEAD two cycles after the handshake; pendingMask[7] clears when the entry pops.
- Fill and back-pressure: A busy continuously, push 2 B entries -> ldReady=0, a third ldValid is held off. After STARVE_LIMIT=4 lost cycles, stallRequest=1. Drop A -> entries drain in order on consecutive cycles, then stallRequest=0 and ldReady=1.
- WAW squash:
  - Push B addr 9 data 0x1111, then A writes addr 9 data 0x2222 while the entry is buffered -> pendingMask[9]=0 and only 0x2222 is ever written to r9.
  - Same-cycle A/B to addr 3 -> B entry discarded.
- Zero address: A wbAddress=0 and B ldAddress=0 -> shouldWrite never asserts, pendingMask stays 0.
- Async reset mid-drain: assert reset_n=0 between clock edges with 2 entries buffered -> all outputs 0 immediately, ldReady=1. After release, no stale write emitted.

Source files
------------

// File: rtl/regfile_writeback_arbiter.sv
// Register file write-port arbiter: pipeline writeback (port A) has priority,
// long-latency results (port B) are queued, WAW-squashed and drained when A is idle.
module regfile_writeback_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 5,
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  wbEnable,
   input  logic [ADDR_WIDTH-1:0] wbAddress,
   input  logic [DATA_WIDTH-1:0] wbData,
   input  logic                  ldValid,
   output logic                  ldReady,
   input  logic [ADDR_WIDTH-1:0] ldAddress,
   input  logic [DATA_WIDTH-1:0] ldData,
   output logic                  shouldWrite,
   output logic [ADDR_WIDTH-1:0] writeAddress,
   output logic [DATA_WIDTH-1:0] writeData,
   output logic [31:0]           pendingMask,
   output logic                  stallRequest
);

   localparam int IW = $clog2(FIFO_DEPTH);
   localparam int PW = IW + 1;
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [FIFO_DEPTH-1:0] ent_vld_q, ent_vld_d;
   logic [ADDR_WIDTH-1:0] ent_addr_q [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] ent_addr_d [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] ent_data_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] ent_data_d [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  should_write_q, should_write_d;
   logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
   logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
   logic [31:0]           mask_q, mask_d;
   logic                  stall_q, stall_d;

   logic          a_act;
   logic          empty;
   logic          full;
   logic [IW-1:0] rd_idx;
   logic [IW-1:0] wr_idx;
   logic          head_vld;
   logic          head_hit;
   logic          pop;
   logic          push;

   always_comb begin
      a_act    = wbEnable && (wbAddress != '0);
      rd_idx   = rd_ptr_q[IW-1:0];
      wr_idx   = wr_ptr_q[IW-1:0];
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[IW] != rd_ptr_q[IW]) && (wr_idx == rd_idx);
      head_vld = !empty && ent_vld_q[rd_idx];
      head_hit = a_act && (ent_addr_q[rd_idx] == wbAddress);
      pop      = !a_act && !empty;
      // B is always older than a same-cycle A to the same register
      push     = ldValid && !full && (ldAddress != '0)
                 && !(a_act && (wbAddress == ldAddress));
   end

   assign ldReady = !full;

   always_comb begin
      ent_vld_d  = ent_vld_q;
      ent_addr_d = ent_addr_q;
      ent_data_d = ent_data_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (a_act && (ent_addr_q[i] == wbAddress)) begin
            ent_vld_d[i] = 1'b0;
         end
      end
      if (pop) begin
         ent_vld_d[rd_idx] = 1'b0;
         rd_ptr_d          = rd_ptr_q + PW'(1);
      end
      if (push) begin
         ent_vld_d[wr_idx]  = 1'b1;
         ent_addr_d[wr_idx] = ldAddress;
         ent_data_d[wr_idx] = ldData;
         wr_ptr_d           = wr_ptr_q + PW'(1);
      end
   end

   always_comb begin
      should_write_d = 1'b0;
      write_addr_d   = write_addr_q;
      write_data_d   = write_data_q;
      if (a_act) begin
         should_write_d = 1'b1;
         write_addr_d   = wbAddress;
         write_data_d   = wbData;
      end else if (pop && head_vld) begin
         should_write_d = 1'b1;
         write_addr_d   = ent_addr_q[rd_idx];
         write_data_d   = ent_data_q[rd_idx];
      end
   end

   always_comb begin
      mask_d = '0;
      for (int r = 1; r < 32; r++) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (ent_vld_d[i] && (ent_addr_d[i] == ADDR_WIDTH'(r))) begin
               mask_d[r] = 1'b1;
            end
         end
      end
   end

   // Counter saturates at the limit so the stall holds until the head pops
   always_comb begin
      cnt_d = '0;
      if (!pop && a_act && head_vld && !head_hit) begin
         cnt_d = (cnt_q < LIMIT) ? cnt_q + 4'd1 : cnt_q;
      end
      stall_d = (cnt_d == LIMIT);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ent_vld_q      <= '0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         cnt_q          <= '0;
         should_write_q <= 1'b0;
         write_addr_q   <= '0;
         write_data_q   <= '0;
         mask_q         <= '0;
         stall_q        <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            ent_addr_q[i] <= '0;
            ent_data_q[i] <= '0;
         end
      end else begin
         ent_vld_q      <= ent_vld_d;
         ent_addr_q     <= ent_addr_d;
         ent_data_q     <= ent_data_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         cnt_q          <= cnt_d;
         should_write_q <= should_write_d;
         write_addr_q   <= write_addr_d;
         write_data_q   <= write_data_d;
         mask_q         <= mask_d;
         stall_q        <= stall_d;
      end
   end

   assign shouldWrite  = should_write_q;
   assign writeAddress = write_addr_q;
   assign writeData    = write_data_q;
   assign pendingMask  = mask_q;
   assign stallRequest = stall_q;

endmodule
